// File: rtl/instr_encoder.sv
// instr_encoder: program loader that range-checks instruction field bundles,
// packs them into 16-bit ISA words and streams them into instruction memory
// at an auto-incrementing byte address.
//
// Handshake: a bundle transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on the FSM state (high in RUN), so one
// bundle can transfer every cycle. The result (write strobe or error pulse) is
// registered and appears in the cycle after the transfer edge.
module instr_encoder #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] LIMIT_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic [2:0]        in_cond,
    input  logic [15:0]       in_imm,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wr_data,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_RANGE = 2'b01;
    localparam logic [1:0] E_ODD   = 2'b10;
    localparam logic [1:0] E_RED   = 2'b11;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic [15:0]        enc_word;
    logic [1:0]         enc_code;
    logic signed [15:0] imm_s;

    assign imm_s = in_imm;

    // Pack the bundle into an ISA word and classify it (E_NONE = writable).
    always_comb begin
        enc_word = 16'h0000;
        enc_code = E_NONE;
        case (in_opcode)
            4'h0, 4'h1, 4'h3, 4'h7: enc_word = {in_opcode, in_rd, in_rs, in_rt};
            4'h2: enc_code = E_RED;
            4'h4, 4'h5, 4'h6: begin
                if (imm_s < 16'sd0 || imm_s > 16'sd15) enc_code = E_RANGE;
                enc_word = {in_opcode, in_rd, in_rs, in_imm[3:0]};
            end
            4'h8: begin
                if (imm_s < -16'sd8 || imm_s > 16'sd7) enc_code = E_RANGE;
                enc_word = {in_opcode, in_rd, in_rs, in_imm[3:0]};
            end
            4'h9: begin
                if (imm_s < -16'sd8 || imm_s > 16'sd7) enc_code = E_RANGE;
                enc_word = {in_opcode, in_rt, in_rs, in_imm[3:0]};
            end
            4'hA, 4'hB: begin
                if (imm_s < 16'sd0 || imm_s > 16'sd255) enc_code = E_RANGE;
                enc_word = {in_opcode, in_rd, in_imm[7:0]};
            end
            4'hC: begin
                // Byte offset; the decoder shifts the stored field left by one.
                if (imm_s < -16'sd512 || imm_s > 16'sd510) enc_code = E_RANGE;
                else if (in_imm[0])                        enc_code = E_ODD;
                enc_word = {in_opcode, in_cond, in_imm[9:1]};
            end
            4'hD: enc_word = {in_opcode, in_cond, 1'b0, in_rs, 4'h0};
            4'hE: enc_word = {in_opcode, in_rd, 8'h00};
            default: enc_word = 16'hF000;
        endcase
    end

    // Next-state and registered-output logic for the load sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wr_en_d = 1'b0;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            S_RUN: begin
                if (in_valid) begin
                    if (enc_code != E_NONE) begin
                        err_d  = 1'b1;
                        code_d = enc_code;
                    end else begin
                        wr_en_d = 1'b1;
                        maddr_d = addr_q;
                        wdata_d = enc_word;
                        count_d = count_q + ADDR_W'(1);
                        // The last legal word ends the load; the address does not wrap.
                        if (addr_q == LIMIT_ADDR) state_d = S_DONE;
                        else                      addr_d  = addr_q + ADDR_W'(2);
                        if (in_opcode == 4'hF) state_d = S_DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = {base_addr[ADDR_W-1:1], 1'b0};
                    count_d = '0;
                end
            end
        endcase
    end

    // State and output registers; reset drops any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wr_en_q <= 1'b0;
            maddr_q <= '0;
            wdata_q <= 16'h0000;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign in_ready    = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign mem_wr_en   = wr_en_q;
    assign mem_addr    = maddr_q;
    assign mem_wr_data = wdata_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign word_count  = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances share the stimulus, one with the
// default end address and one ending at 0x0014; use_lim selects which one's
// outputs are checked against the reference model.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic        in_valid;
    logic [3:0]  in_opcode, in_rd, in_rs, in_rt;
    logic [2:0]  in_cond;
    logic [15:0] in_imm;

    logic        a_ready, a_wr, a_err, a_busy, a_done;
    logic [15:0] a_addr, a_wdata, a_count;
    logic [1:0]  a_code;
    logic        b_ready, b_wr, b_err, b_busy, b_done;
    logic [15:0] b_addr, b_wdata, b_count;
    logic [1:0]  b_code;

    logic        use_lim;
    logic        o_ready, o_wr, o_err, o_busy, o_done;
    logic [15:0] o_addr, o_wdata, o_count;
    logic [1:0]  o_code;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 idle, 1 loading, 2 finished
    int m_state, m_addr, m_count, m_limit;
    bit exp_wr, exp_err;
    int exp_maddr, exp_data, exp_code;
    logic [15:0] exp_q[$];

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(a_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_cond(in_cond),
        .in_imm(in_imm), .mem_wr_en(a_wr), .mem_addr(a_addr),
        .mem_wr_data(a_wdata), .err(a_err), .err_code(a_code),
        .busy(a_busy), .done(a_done), .word_count(a_count)
    );

    instr_encoder #(.ADDR_W(16), .LIMIT_ADDR(16'h0014)) dut_lim (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(b_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_cond(in_cond),
        .in_imm(in_imm), .mem_wr_en(b_wr), .mem_addr(b_addr),
        .mem_wr_data(b_wdata), .err(b_err), .err_code(b_code),
        .busy(b_busy), .done(b_done), .word_count(b_count)
    );

    assign o_ready = use_lim ? b_ready : a_ready;
    assign o_wr    = use_lim ? b_wr    : a_wr;
    assign o_err   = use_lim ? b_err   : a_err;
    assign o_busy  = use_lim ? b_busy  : a_busy;
    assign o_done  = use_lim ? b_done  : a_done;
    assign o_addr  = use_lim ? b_addr  : a_addr;
    assign o_wdata = use_lim ? b_wdata : a_wdata;
    assign o_count = use_lim ? b_count : a_count;
    assign o_code  = use_lim ? b_code  : a_code;

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ISA rules: returns error class (0 ok, 1 range, 2 odd offset, 3 RED) and word
    function automatic void model_encode(input int op, input int rd, input int rs,
                                         input int rt, input int cond, input int imm,
                                         output int code, output int word);
        code = 0;
        word = 0;
        case (op)
            0, 1, 3, 7: word = op * 4096 + rd * 256 + rs * 16 + rt;
            2: code = 3;
            4, 5, 6: if (imm < 0 || imm > 15) code = 1;
                     else word = op * 4096 + rd * 256 + rs * 16 + imm;
            8: if (imm < -8 || imm > 7) code = 1;
               else word = op * 4096 + rd * 256 + rs * 16 + (imm & 15);
            9: if (imm < -8 || imm > 7) code = 1;
               else word = op * 4096 + rt * 256 + rs * 16 + (imm & 15);
            10, 11: if (imm < 0 || imm > 255) code = 1;
                    else word = op * 4096 + rd * 256 + imm;
            12: if (imm < -512 || imm > 510) code = 1;
                else if (imm % 2 != 0) code = 2;
                else word = op * 4096 + cond * 512 + ((imm / 2) & 511);
            13: word = op * 4096 + cond * 512 + rs * 16;
            14: word = op * 4096 + rd * 256;
            default: word = 'hF000;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_addr = 0; m_count = 0;
        exp_wr = 0; exp_err = 0; exp_maddr = 0; exp_data = 0; exp_code = 0;
        exp_q.delete();
    endtask

    // One clock cycle of stimulus, model update and full output comparison
    task automatic step(input bit st, input int base, input bit v, input int op,
                        input int rd, input int rs, input int rt, input int cond,
                        input logic [15:0] imm);
        int code, word;
        start = st; base_addr = 16'(base); in_valid = v;
        in_opcode = op[3:0]; in_rd = rd[3:0]; in_rs = rs[3:0]; in_rt = rt[3:0];
        in_cond = cond[2:0]; in_imm = imm;
        checks++;
        if (o_ready !== (m_state == 1)) begin
            errors++; $display("FAIL in_ready: got %b expected %b", o_ready, m_state == 1);
        end
        @(posedge clk); #1;
        exp_wr = 0; exp_err = 0;
        if (m_state == 1) begin
            if (v) begin
                model_encode(op, rd, rs, rt, cond, int'($signed(imm)), code, word);
                if (code != 0) begin
                    exp_err = 1; exp_code = code;
                end else begin
                    exp_wr = 1; exp_q.push_back(16'(word)); exp_maddr = m_addr;
                    m_count = (m_count + 1) % 65536;
                    if (m_addr == m_limit) m_state = 2;
                    else m_addr = (m_addr + 2) % 65536;
                    if (op == 15) m_state = 2;
                end
            end
        end else if (st) begin
            m_state = 1; m_addr = base & 'hFFFE; m_count = 0;
        end
        if (exp_wr) exp_data = int'(exp_q.pop_front());
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (o_wr !== exp_wr) begin
            errors++; $display("FAIL mem_wr_en: got %b expected %b", o_wr, exp_wr);
        end
        checks++;
        if (o_err !== exp_err) begin
            errors++; $display("FAIL err: got %b expected %b", o_err, exp_err);
        end
        checks++;
        if (o_code !== 2'(exp_code)) begin
            errors++; $display("FAIL err_code: got %0d expected %0d", o_code, exp_code);
        end
        checks++;
        if (o_busy !== (m_state == 1) || o_done !== (m_state == 2)) begin
            errors++; $display("FAIL busy_done: got %b%b expected %b%b",
                               o_busy, o_done, m_state == 1, m_state == 2);
        end
        checks++;
        if (o_count !== 16'(m_count)) begin
            errors++; $display("FAIL word_count: got %0d expected %0d", o_count, m_count);
        end
        checks++;
        if (o_addr !== 16'(exp_maddr)) begin
            errors++; $display("FAIL mem_addr: got %h expected %h", o_addr, 16'(exp_maddr));
        end
        checks++;
        if (o_wdata !== 16'(exp_data)) begin
            errors++; $display("FAIL mem_wr_data: got %h expected %h", o_wdata, 16'(exp_data));
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({o_ready, o_wr, o_err, o_busy, o_done, o_code} !== 7'b0 ||
            o_addr !== 16'h0 || o_wdata !== 16'h0 || o_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy%b wr%b err%b busy%b done%b code%0d addr%h data%h cnt%0d expected all zero",
                     o_ready, o_wr, o_err, o_busy, o_done, o_code, o_addr, o_wdata, o_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        use_lim = 1'b0; m_limit = 'hFFFE;
        @(posedge clk); #1;
        apply_reset();
    endtask

    task automatic test_add();
        step(1, 'h0010, 0, 0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 0, 1, 2, 3, 0, 16'h0);
        checks++;
        if (o_wdata !== 16'h0123 || o_addr !== 16'h0010 || o_count !== 16'd1) begin
            errors++; $display("FAIL add_word: got %h@%h cnt %0d expected 0123@0010 cnt 1",
                               o_wdata, o_addr, o_count);
        end
        step(0, 0, 1, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (o_wr !== 1'b1 || o_wdata !== 16'h0000 || o_addr !== 16'h0012) begin
            errors++; $display("FAIL nop_word: got wr%b %h@%h expected wr1 0000@0012",
                               o_wr, o_wdata, o_addr);
        end
    endtask

    task automatic test_shift();
        step(0, 0, 1, 4, 4, 5, 0, 0, 16'd3);
        checks++;
        if (o_wdata !== 16'h4453 || o_addr !== 16'h0014) begin
            errors++; $display("FAIL sll_word: got %h@%h expected 4453@0014", o_wdata, o_addr);
        end
        step(0, 0, 1, 4, 4, 5, 0, 0, 16'd16);
        checks++;
        if (o_err !== 1'b1 || o_code !== 2'b01 || o_wr !== 1'b0) begin
            errors++; $display("FAIL sll_range: got err%b code%0d wr%b expected err1 code1 wr0",
                               o_err, o_code, o_wr);
        end
        step(0, 0, 1, 6, 2, 3, 0, 0, 16'd15);
        checks++;
        if (o_wdata !== 16'h623F || o_addr !== 16'h0016) begin
            errors++; $display("FAIL ror_word: got %h@%h expected 623F@0016", o_wdata, o_addr);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1, 8, 1, 2, 0, 0, 16'hFFFF);
        checks++;
        if (o_wdata !== 16'h812F) begin
            errors++; $display("FAIL lw_word: got %h expected 812F", o_wdata);
        end
        step(0, 0, 1, 9, 0, 7, 6, 0, 16'd7);
        checks++;
        if (o_wr !== 1'b1 || o_wdata !== 16'h9677) begin
            errors++; $display("FAIL sw_word: got wr%b %h expected wr1 9677", o_wr, o_wdata);
        end
        step(0, 0, 1, 8, 1, 2, 0, 0, 16'hFFF7);
        step(0, 0, 1, 10, 3, 0, 0, 0, 16'd255);
        step(0, 0, 1, 11, 3, 0, 0, 0, 16'd256);
    endtask

    task automatic test_branch();
        step(0, 0, 1, 12, 0, 0, 0, 3, 16'hFFFC);
        checks++;
        if (o_wdata !== 16'hC7FE) begin
            errors++; $display("FAIL b_word: got %h expected C7FE", o_wdata);
        end
        step(0, 0, 1, 12, 0, 0, 0, 3, 16'd5);
        checks++;
        if (o_code !== 2'b10 || o_err !== 1'b1) begin
            errors++; $display("FAIL b_odd: got err%b code%0d expected err1 code2", o_err, o_code);
        end
        step(0, 0, 1, 12, 0, 0, 0, 3, 16'd512);
        checks++;
        if (o_code !== 2'b01) begin
            errors++; $display("FAIL b_range: got code%0d expected code1", o_code);
        end
        step(0, 0, 1, 12, 0, 0, 0, 1, 16'd510);
        step(0, 0, 1, 12, 0, 0, 0, 7, 16'hFE00);
        step(0, 0, 1, 2, 1, 2, 3, 0, 16'h0);
        checks++;
        if (o_code !== 2'b11) begin
            errors++; $display("FAIL red_reject: got code%0d expected code3", o_code);
        end
        step(0, 0, 1, 13, 0, 9, 0, 5, 16'h0);
        step(0, 0, 1, 14, 12, 0, 0, 0, 16'h0);
    endtask

    task automatic test_halt();
        step(0, 0, 1, 15, 1, 2, 3, 0, 16'h0);
        checks++;
        if (o_wdata !== 16'hF000 || o_done !== 1'b1) begin
            errors++; $display("FAIL hlt: got %h done%b expected F000 done1", o_wdata, o_done);
        end
        step(0, 0, 1, 0, 1, 1, 1, 0, 16'h0);
        step(0, 0, 1, 0, 1, 1, 1, 0, 16'h0);
        step(1, 'h0021, 0, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (o_busy !== 1'b1 || o_count !== 16'd0) begin
            errors++; $display("FAIL restart: got busy%b cnt%0d expected busy1 cnt0", o_busy, o_count);
        end
        step(0, 0, 1, 1, 1, 2, 3, 0, 16'h0);
        checks++;
        if (o_addr !== 16'h0020) begin
            errors++; $display("FAIL restart_addr: got %h expected 0020", o_addr);
        end
    endtask

    task automatic test_limit();
        use_lim = 1'b1; m_limit = 'h0014;
        apply_reset();
        step(1, 'h0010, 0, 0, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, i, 1, 2, 0, 16'h0);
        checks++;
        if (o_addr !== 16'h0014 || o_done !== 1'b1 || o_count !== 16'd3) begin
            errors++; $display("FAIL limit_end: got %h done%b cnt%0d expected 0014 done1 cnt3",
                               o_addr, o_done, o_count);
        end
        step(0, 0, 1, 0, 5, 5, 5, 0, 16'h0);
        step(1, 'h0012, 0, 0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 3, 1, 1, 1, 0, 16'h0);
        step(0, 0, 1, 15, 0, 0, 0, 0, 16'h0);
        step(1, 'h0014, 0, 0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 15, 0, 0, 0, 0, 16'h0);
        step(1, 'h0010, 0, 0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 7, 2, 3, 4, 0, 16'h0);
        // Asynchronous reset mid-load with a bundle in flight
        in_valid = 1'b1; in_opcode = 4'h1;
        #2;
        apply_reset();
        step(0, 0, 1, 0, 1, 2, 3, 0, 16'h0);
    endtask

    task automatic test_random(input bit lim, input int n);
        int op, r, imm, base_max;
        bit st;
        use_lim = lim;
        m_limit = lim ? 'h0014 : 'hFFFE;
        base_max = lim ? 'h0014 : 'h0200;
        apply_reset();
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 15);
            if (op == 15 && $urandom_range(0, 5) != 0) op = 0;
            r = $urandom_range(0, 3);
            case (r)
                0: imm = $urandom_range(0, 15);
                1: imm = $urandom_range(0, 300);
                2: imm = -$urandom_range(0, 600);
                default: imm = $urandom;
            endcase
            st = (m_state != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step(st, $urandom_range(0, base_max), $urandom_range(0, 3) != 0, op,
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 7), 16'(imm));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 16'h0; in_valid = 1'b0;
        in_opcode = 4'h0; in_rd = 4'h0; in_rs = 4'h0; in_rt = 4'h0;
        in_cond = 3'h0; in_imm = 16'h0; use_lim = 1'b0;
        model_reset();
        m_limit = 'hFFFE;
        test_reset();
        test_add();
        test_shift();
        test_back_to_back();
        test_branch();
        test_halt();
        test_limit();
        test_random(1'b0, 400);
        test_random(1'b1, 400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
